hdmi_pattern_gen: RTL and testbench

HDMI_PATTERN_GEN -- requirements
Module: hdmi_pattern_gen

---
 rtl/hdmi_pattern_pkg.sv | 52 +++++
 rtl/hdmi_timing_counter.sv | 57 +++++
 rtl/hdmi_pattern_gen.sv | 111 +++++++++++
 tb/tb_hdmi_pattern_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pattern_pkg.sv
// rtl/hdmi_pattern_pkg.sv - timing defaults, mode encodings and colour constants for the HDMI pattern generator
package hdmi_pattern_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef enum logic [2:0] {
      MODE_BLACK   = 3'd0,
      MODE_WHITE   = 3'd1,
      MODE_RED     = 3'd2,
      MODE_GREEN   = 3'd3,
      MODE_BLUE    = 3'd4,
      MODE_BARS    = 3'd5,
      MODE_CHECKER = 3'd6,
      MODE_GRAD    = 3'd7
   } mode_e;

   localparam logic [23:0] COL_BLACK   = 24'h000000;
   localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] COL_RED     = 24'hFF0000;
   localparam logic [23:0] COL_GREEN   = 24'h00FF00;
   localparam logic [23:0] COL_BLUE    = 24'h0000FF;
   localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
   localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;

   // Classic colour-bar order, left to right.
   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0: c = COL_WHITE;
         3'd1: c = COL_YELLOW;
         3'd2: c = COL_CYAN;
         3'd3: c = COL_GREEN;
         3'd4: c = COL_MAGENTA;
         3'd5: c = COL_RED;
         3'd6: c = COL_BLUE;
         3'd7: c = COL_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// rtl/hdmi_timing_counter.sv - raster h/v counters with combinational sync and data-enable decode
module hdmi_timing_counter
   import hdmi_pattern_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_end,
   output logic          origin
);

   localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic h_last;
   logic v_last;

   assign h_last = (h_cnt == HW'(LINE_LEN - 1));
   assign v_last = (v_cnt == VW'(FRAME_LINES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign de        = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign hsync     = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
   assign vsync     = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
   assign frame_end = h_last && v_last;
   assign origin    = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/hdmi_pattern_gen.sv
// rtl/hdmi_pattern_gen.sv - test-pattern source with registered sync/de/rgb; HDMI_PATTERN_SCROLL_EN adds horizontal scrolling
module hdmi_pattern_gen
   import hdmi_pattern_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic [2:0]  mode,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [23:0] rgb,
   output logic        frame_start
);

   localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam int BAR_W = H_ACTIVE / 8;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          de_c;
   logic          hsync_c;
   logic          vsync_c;
   logic          frame_end;
   logic          origin;
   mode_e         mode_q;
   logic [10:0]   px;
   logic [2:0]    bar_idx;
   logic          y5;
   logic [23:0]   pattern;

   hdmi_timing_counter #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .h_cnt(h_cnt), .v_cnt(v_cnt),
      .de(de_c), .hsync(hsync_c), .vsync(vsync_c),
      .frame_end(frame_end), .origin(origin)
   );

   // Sampled only on the last pixel so a whole frame always uses one pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mode_q <= MODE_BLACK;
      else if (pix_en && frame_end)
         mode_q <= mode_e'(mode);
   end

`ifdef HDMI_PATTERN_SCROLL_EN
   logic [9:0] offset;

   // Advanced at the frame boundary so every pixel of a frame sees the same offset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         offset <= '0;
      else if (pix_en && frame_end)
         offset <= offset + 10'd1;
   end

   assign px      = 11'(h_cnt) + 11'(offset);
   assign bar_idx = 3'((px % H_ACTIVE) / BAR_W);
`else
   assign px      = 11'(h_cnt);
   assign bar_idx = 3'(px / BAR_W);
`endif

   assign y5 = |(v_cnt & VW'(32));

   always_comb begin
      pattern = COL_BLACK;
      case (mode_q)
         MODE_BLACK:   pattern = COL_BLACK;
         MODE_WHITE:   pattern = COL_WHITE;
         MODE_RED:     pattern = COL_RED;
         MODE_GREEN:   pattern = COL_GREEN;
         MODE_BLUE:    pattern = COL_BLUE;
         MODE_BARS:    pattern = bar_colour(bar_idx);
         MODE_CHECKER: pattern = (px[5] ^ y5) ? COL_WHITE : COL_BLACK;
         MODE_GRAD:    pattern = {3{px[9:2]}};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         rgb         <= COL_BLACK;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         hsync       <= hsync_c;
         vsync       <= vsync_c;
         de          <= de_c;
         rgb         <= de_c ? pattern : COL_BLACK;
         frame_start <= origin;
      end
   end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb/tb_hdmi_pattern_gen.sv - self-checking bench for hdmi_pattern_gen on a reduced raster
module tb_hdmi_pattern_gen;

   localparam int HA = 128, HF = 8, HS = 16, HB = 8;
   localparam int VA = 36, VF = 2, VS = 3, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int BW = HA / 8;
   localparam int LIMIT = 20000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en = 1'b1;
   logic [2:0]  mode = 3'd0;
   logic        hsync, vsync, de, frame_start;
   logic [23:0] rgb;

   int n_checks = 0;
   int n_fail = 0;
   bit toggle = 1'b0;

   hdmi_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
      .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      pix_en = toggle ? !pix_en : 1'b1;
   end

   // Model: which pixel the outputs currently show, and the frame's mode/offset.
   bit started = 1'b0;
   int mx = 0, my = 0, frame_no = 0, frame_mode = 0, latched_mode = 0, offset = 0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         started = 1'b0; mx = 0; my = 0; frame_no = 0;
         frame_mode = 0; latched_mode = 0; offset = 0;
      end else if (pix_en) begin
         if (!started) begin
            started = 1'b1; mx = 0; my = 0;
         end else begin
            mx++;
            if (mx == HT) begin
               mx = 0;
               my++;
               if (my == VT) begin
                  my = 0;
                  frame_no++;
                  frame_mode = latched_mode;
`ifdef HDMI_PATTERN_SCROLL_EN
                  offset = (offset + 1) % 1024;
`endif
               end
            end
         end
         if (mx == HT - 1 && my == VT - 1) latched_mode = int'(mode);
      end
   end

   function automatic logic [28:0] model_out();
      logic [23:0] c;
      bit de_m;
      int xo;
      if (!started) return {1'b1, 1'b1, 1'b0, 24'h0, 1'b0};
      de_m = (mx < HA) && (my < VA);
      xo = mx + offset;
      case (frame_mode)
         1: c = 24'hFFFFFF;
         2: c = 24'hFF0000;
         3: c = 24'h00FF00;
         4: c = 24'h0000FF;
         5: c = bars[(xo % HA) / BW];
         6: c = (((xo / 32) + (my / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
         7: c = {3{8'((xo / 4) % 256)}};
         default: c = 24'h000000;
      endcase
      if (!de_m) c = 24'h0;
      return {!(mx >= HA + HF && mx < HA + HF + HS), !(my >= VA + VF && my < VA + VF + VS),
              de_m, c, (mx == 0 && my == 0)};
   endfunction

   always @(negedge clk) begin
      logic [28:0] exp_v;
      logic [28:0] act_v;
      exp_v = model_out();
      act_v = {hsync, vsync, de, rgb, frame_start};
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL model_cmp frame %0d pixel (%0d,%0d): got %h want %h", frame_no, mx, my, act_v, exp_v);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_pixel(input int f, input int x, input int y);
      int n = 0;
      while (!(started && frame_no == f && mx == x && my == y) && n < 3 * LIMIT) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 3 * LIMIT) begin
         n_fail++;
         $display("FAIL wait_pixel f%0d (%0d,%0d): got timeout want reached", f, x, y);
      end
   endtask

   task automatic measure_frame(output int per, output int hs, output int vs, output int dh, output int fsn);
      int n = 0;
      bit prev;
      per = 0; hs = 0; vs = 0; dh = 0; fsn = 0;
      while (!frame_start && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      while (per < 2 * LIMIT) begin
         if (!hsync) hs++;
         if (!vsync) vs++;
         if (de) dh++;
         if (frame_start) fsn++;
         prev = frame_start;
         @(negedge clk);
         per++;
         if (frame_start && !prev) break;
      end
   endtask

   initial begin
      int per, hs, vs, dh, fsn;
      reset = 1'b1;
      mode = 3'd5;
      repeat (3) @(negedge clk);
      check("reset_hsync", hsync, 1);
      check("reset_vsync", vsync, 1);
      check("reset_de", de, 0);
      check("reset_rgb", rgb, 0);
      check("reset_fs", frame_start, 0);

      reset = 1'b0;
      @(negedge clk);
      check("first_fs", frame_start, 1);
      check("first_de", de, 1);
      check("first_rgb", rgb, 0);

      measure_frame(per, hs, vs, dh, fsn);
      check("frame_period", per, 7040);
      check("hsync_low_cycles", hs, 704);
      check("vsync_low_cycles", vs, 480);
      check("de_high_cycles", dh, 4608);
      check("fs_high_cycles", fsn, 1);

      wait_pixel(1, 0, 0);    check("bar_x0", rgb, 24'hFFFFFF);
      wait_pixel(1, 15, 0);   check("bar_x15", rgb, 24'hFFFFFF);
      wait_pixel(1, 16, 0);   check("bar_x16", rgb, 24'hFFFF00);
      wait_pixel(1, 80, 0);   check("bar_x80", rgb, 24'hFF0000);
      wait_pixel(1, 96, 0);   check("bar_x96", rgb, 24'h0000FF);
      wait_pixel(1, 127, 0);  check("bar_x127", rgb, 24'h000000); check("bar_x127_de", de, 1);
      wait_pixel(1, 128, 0);  check("bar_x128", rgb, 24'h000000); check("bar_x128_de", de, 0);

      mode = 3'd1;
      wait_pixel(2, 0, 10);   mode = 3'd2;
      wait_pixel(2, 0, 20);   check("white_after_change", rgb, 24'hFFFFFF);
      wait_pixel(3, 0, 0);    check("red_next_frame", rgb, 24'hFF0000);

      mode = 3'd6;
      wait_pixel(4, 0, 0);    check("chk_0_0", rgb, 24'h000000);
      wait_pixel(4, 32, 0);   check("chk_32_0", rgb, 24'hFFFFFF);
      wait_pixel(4, 0, 32);   check("chk_0_32", rgb, 24'hFFFFFF);
      wait_pixel(4, 32, 32);  check("chk_32_32", rgb, 24'h000000);

      mode = 3'd7;
      wait_pixel(5, 100, 0);  check("grad_100", rgb, 24'h191919);
      wait_pixel(5, 127, 35); check("grad_127", rgb, 24'h1F1F1F);

      mode = 3'd4;
      toggle = 1'b1;
      measure_frame(per, hs, vs, dh, fsn);
      check("toggled_frame_period", per, 14080);
      check("blue_origin", rgb, 24'h0000FF);
      toggle = 1'b0;

      wait_pixel(7, 50, 20);
      check("pre_reset_de", de, 1);
      #3 reset = 1'b1;
      #1;
      check("async_hsync", hsync, 1);
      check("async_vsync", vsync, 1);
      check("async_de", de, 0);
      check("async_rgb", rgb, 0);
      check("async_fs", frame_start, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("restart_fs", frame_start, 1);
      check("restart_de", de, 1);
      check("restart_rgb", rgb, 0);

      repeat (200) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
